// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port main-memory arbiter
package mem_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;
  typedef enum logic {OP_RD, OP_WR} mem_op_t;

  localparam int WORD_W = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - line-swap handshake bundle (level request, one-cycle gnt)
interface mem_arbiter_if #(
  parameter int ADDR_LEN      = 10,
  parameter int LINE_ADDR_LEN = 3
);
  localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN;
  localparam int LINE_W    = 32 * LINE_SIZE;

  logic                rd_req;
  logic                wr_req;
  logic [ADDR_LEN-1:0] addr;
  logic [LINE_W-1:0]   wr_line;
  logic                gnt;
  logic [LINE_W-1:0]   rd_line;

  modport master (output rd_req, wr_req, addr, wr_line, input gnt, rd_line);
  modport slave  (input rd_req, wr_req, addr, wr_line, output gnt, rd_line);

endinterface

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational 2-way picker; round-robin by default,
// fixed priority (requester 0 first) when MEM_ARB_FIXED_PRIO_EN is defined
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic       valid_o,
  output req_id_t    winner_o
);

  assign valid_o = |req_i;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner_o = req_i[0] ? REQ_I : REQ_D;
  end
`else
  always_comb begin
    winner_o = REQ_I;
    if (req_i == 2'b11) begin
      winner_o = (last_i == REQ_I) ? REQ_D : REQ_I;
    end else if (req_i[1]) begin
      winner_o = REQ_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises I-side and D-side line swaps onto one main memory;
// MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_LEN      = 10,
  parameter int LINE_ADDR_LEN = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master mem
);

  localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN;
  localparam int LINE_W    = WORD_W * LINE_SIZE;

  arb_state_t          state_q, state_d;
  req_id_t             owner_q, owner_d;
  req_id_t             last_q, last_d;
  mem_op_t             op_q, op_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]   wr_line_q, wr_line_d;
  logic [LINE_W-1:0]   rd_line_q, rd_line_d;

  logic [1:0] req_active;
  logic       pick_valid;
  req_id_t    pick_winner;

  assign req_active = {m1.rd_req | m1.wr_req, m0.rd_req | m0.wr_req};

  arb_rr_pick u_pick (
    .req_i   (req_active),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .winner_o(pick_winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= REQ_I;
      last_q    <= REQ_D;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wr_line_q <= '0;
      rd_line_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wr_line_q <= wr_line_d;
      rd_line_q <= rd_line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wr_line_d = wr_line_q;
    rd_line_d = rd_line_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          owner_d = pick_winner;
          last_d  = pick_winner;
          // rd and wr both high counts as a write
          if (pick_winner == REQ_D) begin
            op_d      = m1.wr_req ? OP_WR : OP_RD;
            addr_d    = m1.addr;
            wr_line_d = m1.wr_line;
          end else begin
            op_d      = m0.wr_req ? OP_WR : OP_RD;
            addr_d    = m0.addr;
            wr_line_d = m0.wr_line;
          end
        end
      end
      BUSY: begin
        if (mem.gnt) begin
          state_d = IDLE;
          if (op_q == OP_RD) begin
            rd_line_d = mem.rd_line;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // memory side sees only latched state, so requesters may change freely once granted
  assign mem.rd_req  = (state_q == BUSY) && (op_q == OP_RD);
  assign mem.wr_req  = (state_q == BUSY) && (op_q == OP_WR);
  assign mem.addr    = addr_q;
  assign mem.wr_line = wr_line_q;

  assign m0.gnt     = mem.gnt && (state_q == BUSY) && (owner_q == REQ_I);
  assign m1.gnt     = mem.gnt && (state_q == BUSY) && (owner_q == REQ_D);
  assign m0.rd_line = rd_line_q;
  assign m1.rd_line = rd_line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter with a
// 20-cycle main-memory model and a rule-level arbitration reference
module tb_mem_arbiter;

  localparam int LAT = 20;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    bit           wr;
    logic [9:0]   addr;
    logic [255:0] line;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_LEN(10), .LINE_ADDR_LEN(3)) m0_if ();
  mem_arbiter_if #(.ADDR_LEN(10), .LINE_ADDR_LEN(3)) m1_if ();
  mem_arbiter_if #(.ADDR_LEN(10), .LINE_ADDR_LEN(3)) mem_if ();

  mem_arbiter #(.ADDR_LEN(10), .LINE_ADDR_LEN(3)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .m0   (m0_if),
    .m1   (m1_if),
    .mem  (mem_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  txn_t exp_q0[$];
  txn_t exp_q1[$];
  int   exp_owner[$];
  int   grant_log[$];
  logic [255:0] ref_mem[int];
  logic [255:0] mem_store[int];
  logic [255:0] last_rd_exp = '0;
  int   model_last = 1;
  bit   mon_en = 1'b1;
  bit   resp_en = 1'b1;
  int   resp_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [9:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {8'hC0, 6'd0, a, 5'd0, 3'(w)};
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] ref_read(input logic [9:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_line(a);
  endfunction

  // main memory: answers after LAT busy cycles, junk on rd_line otherwise
  initial begin
    mem_if.gnt = 1'b0;
    mem_if.rd_line = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        mem_if.gnt = 1'b0;
        mem_if.rd_line = rand_line();
        if (rst) resp_cnt = 0;
        else if (mem_if.rd_req || mem_if.wr_req) begin
          resp_cnt++;
          if (resp_cnt == LAT) begin
            resp_cnt = 0;
            mem_if.gnt = 1'b1;
            if (mem_if.wr_req) mem_store[int'(mem_if.addr)] = mem_if.wr_line;
            else mem_if.rd_line = mem_store.exists(int'(mem_if.addr)) ?
                                  mem_store[int'(mem_if.addr)] : init_line(mem_if.addr);
          end
        end else resp_cnt = 0;
      end
    end
  end

  task automatic drive(input int id, input bit rd, input bit wr, input logic [9:0] a,
                       input logic [255:0] l);
    if (id == 0) begin
      m0_if.rd_req = rd; m0_if.wr_req = wr; m0_if.addr = a; m0_if.wr_line = l;
    end else begin
      m1_if.rd_req = rd; m1_if.wr_req = wr; m1_if.addr = a; m1_if.wr_line = l;
    end
  endtask

  task automatic do_req(input int id, input bit rd, input bit wr, input logic [9:0] a,
                        input logic [255:0] l);
    txn_t t;
    bit got;
    t.wr = wr; t.addr = a; t.line = l;
    if (id == 0) exp_q0.push_back(t); else exp_q1.push_back(t);
    drive(id, rd, wr, a, l);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      got = (id == 0) ? m0_if.gnt : m1_if.gnt;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL req%0d_timeout: got no gnt expected gnt within 400 cycles", id);
    end
    @(posedge clk);
    #1;
    drive(id, 1'b0, 1'b0, 10'd0, '0);
  endtask

  task automatic rand_req(input int id);
    int k;
    k = $urandom_range(0, 3);
    do_req(id, k != 2, k >= 2, 10'($urandom), rand_line());
  endtask

  task automatic rand_stream(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      rand_req(id);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_last = 1;
    last_rd_exp = '0;
  endtask

  // monitor: arbitration rule at each transaction start, scoreboard pop at each gnt
  bit [1:0] pend_now = '0, prev_pend = '0;
  bit prev_act = 1'b0, chk_rd_next = 1'b0, chk_idle_next = 1'b0;
  always @(negedge clk) begin : mon
    bit act;
    int w, id, eo;
    txn_t t;
    act = mem_if.rd_req | mem_if.wr_req;
    prev_pend = pend_now;
    pend_now = {m1_if.rd_req | m1_if.wr_req, m0_if.rd_req | m0_if.wr_req};
    if (mon_en && !rst) begin
      if (chk_idle_next) check("idle_gap_req", act, 0);
      if (chk_rd_next) begin
        check("m0_rd_line", m0_if.rd_line, last_rd_exp);
        check("m1_rd_line", m1_if.rd_line, last_rd_exp);
      end
      chk_idle_next = 1'b0;
      chk_rd_next = 1'b0;
      if (act && !prev_act) begin
        if (prev_pend == 2'b11) w = FIXED ? 0 : 1 - model_last;
        else if (prev_pend[0]) w = 0;
        else if (prev_pend[1]) w = 1;
        else w = -1;
        if (w < 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_start: got mem request expected none (no requester active)");
        end else begin
          model_last = w;
          exp_owner.push_back(w);
          if ((w == 0 && exp_q0.size() > 0) || (w == 1 && exp_q1.size() > 0)) begin
            t = (w == 0) ? exp_q0[0] : exp_q1[0];
            check("start_addr", mem_if.addr, t.addr);
            check("start_op", {mem_if.rd_req, mem_if.wr_req}, {!t.wr, t.wr});
          end
        end
      end
      if (m0_if.gnt || m1_if.gnt) begin
        id = m1_if.gnt ? 1 : 0;
        check("gnt_exclusive", m0_if.gnt & m1_if.gnt, 0);
        check("gnt_needs_mem_gnt", mem_if.gnt, 1);
        eo = (exp_owner.size() > 0) ? exp_owner.pop_front() : -1;
        check("gnt_owner", id, eo);
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
          n_cmp++; n_bad++;
          $display("FAIL gnt_unexpected: got gnt to %0d expected no outstanding txn", id);
        end else begin
          t = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("gnt_addr", mem_if.addr, t.addr);
          check("gnt_op", {mem_if.rd_req, mem_if.wr_req}, {!t.wr, t.wr});
          if (t.wr) begin
            check("wr_line", mem_if.wr_line, t.line);
            ref_mem[int'(t.addr)] = t.line;
          end else last_rd_exp = ref_read(t.addr);
        end
        grant_log.push_back(id);
        chk_rd_next = 1'b1;
        chk_idle_next = 1'b1;
      end
    end
    prev_act = act;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 50000 cycles");
    $fatal(1);
  end

  initial begin
    bit seen;
    drive(0, 1'b0, 1'b0, 10'd0, '0);
    drive(1, 1'b0, 1'b0, 10'd0, '0);
    do_reset();
    check("rst_mem_rd_req", mem_if.rd_req, 0);
    check("rst_mem_wr_req", mem_if.wr_req, 0);
    check("rst_gnts", {m0_if.gnt, m1_if.gnt}, 0);
    check("rst_mem_addr", mem_if.addr, 0);
    check("rst_mem_wr_line", mem_if.wr_line, 0);
    check("rst_m_rd_line", m0_if.rd_line, 0);

    // single read, request visible to memory one cycle after sampling
    fork
      do_req(0, 1'b1, 1'b0, 10'h05A, '0);
      begin
        @(posedge clk); #1;
        check("arb_latency_rd_req", mem_if.rd_req, 1);
        check("arb_latency_addr", mem_if.addr, 10'h05A);
      end
    join

    // first contention after reset goes to requester 0
    do_reset();
    grant_log.delete();
    fork
      do_req(0, 1'b1, 1'b0, 10'h001, '0);
      do_req(1, 1'b0, 1'b1, 10'h3FF, rand_line());
    join
    check("first_contention_n", grant_log.size(), 2);
    check("first_contention_0", grant_log[0], 0);

    // sustained contention
    do_reset();
    grant_log.delete();
    fork
      repeat (6) rand_req(0);
      repeat (6) rand_req(1);
    join
    for (int i = 0; i < 6; i++) check("sustained_order", grant_log[i], FIXED ? 0 : i % 2);

    // write-back then refill on m1 while m0 waits
    repeat (2) @(posedge clk);
    #1;
    grant_log.delete();
    fork
      begin
        do_req(1, 1'b0, 1'b1, 10'h010, rand_line());
        do_req(1, 1'b1, 1'b0, 10'h011, '0);
      end
      begin
        @(posedge clk); #1;
        do_req(0, 1'b1, 1'b0, 10'($urandom), '0);
      end
    join
    check("swap_n", grant_log.size(), 3);
    check("swap_order", {grant_log[0][1:0], grant_log[1][1:0], grant_log[2][1:0]}, 6'b01_00_01);

    // rd and wr both high is a write
    do_req(1, 1'b1, 1'b1, 10'h020, rand_line());

    // random phase, random gaps
    fork
      rand_stream(0, 8);
      rand_stream(1, 8);
    join

    // reset mid-BUSY, stray gnt ignored
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    resp_en = 1'b0;
    mem_if.gnt = 1'b0;
    drive(0, 1'b1, 1'b0, 10'h0AB, '0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(posedge clk); #1; seen = mem_if.rd_req; end
    check("rst_test_started", seen, 1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 10'd0, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy_rd_req", mem_if.rd_req, 0);
    check("rst_busy_wr_req", mem_if.wr_req, 0);
    check("rst_busy_m_rd_line", m0_if.rd_line, 0);
    mem_if.gnt = 1'b1;
    @(negedge clk);
    check("stray_gnt", {m0_if.gnt, m1_if.gnt}, 0);
    @(posedge clk);
    #1;
    mem_if.gnt = 1'b0;
    exp_q0.delete(); exp_q1.delete(); exp_owner.delete();
    model_last = 1;
    last_rd_exp = '0;
    resp_cnt = 0;
    resp_en = 1'b1;
    mon_en = 1'b1;
    grant_log.delete();
    fork
      rand_req(1);
      rand_req(0);
    join
    check("post_rst_first", grant_log[0], 0);

    repeat (5) @(posedge clk);
    check("drain_owner_q", exp_owner.size(), 0);
    check("drain_exp_q", exp_q0.size() + exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single slow main memory between the instruction-side and data-side caches. Each cache keeps its existing main-memory handshake (level request held until a one-cycle grant). The arbiter serialises the two caches' line swaps onto `main_mem` with round-robin fairness. It registers the winning request and buffers the returned read line so each cache sees the same interface it would see with a private memory.

## Interface
- `LINE_ADDR_LEN`, 3, log2 of words per line; a line is `2**LINE_ADDR_LEN` 32-bit words.
- `ADDR_LEN`, 10, main-memory line-address width (tag + set).
- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_rd_req`, `m1_rd_req`  in  1  line-read request from requester 0 (I-side) and requester 1 (D-side).
- `m0_wr_req`, `m1_wr_req`  in  1  line-write request.
- `m0_addr`, `m1_addr`  in  ADDR_LEN  line address.
- `m0_wr_line`, `m1_wr_line`  in  32 x LINE_SIZE  line to write.
- `m0_gnt`, `m1_gnt`  out  1  one-cycle completion pulse to the owning requester.
- `m_rd_line`  out  32 x LINE_SIZE  buffered read line, shared by both requesters.
- `mem_rd_req`, `mem_wr_req`  out  1  request to `main_mem`.
- `mem_addr`  out  ADDR_LEN  line address to `main_mem`.
- `mem_wr_line`  out  32 x LINE_SIZE  write line to `main_mem`.
- `mem_gnt`  in  1  completion pulse from `main_mem`.
- `mem_rd_line`  in  32 x LINE_SIZE  read line from `main_mem`, valid when `mem_gnt` is high.

## Operation
- States:
  - IDLE: no transaction; `mem_*_req` low.
  - BUSY: one transaction outstanding to `main_mem` for the latched owner.
- IDLE: a requester is active if its rd or wr request is high.
  - If none is active, stay in IDLE.
  - If one is active, it wins.
  - If both are active, the requester other than `last_owner` wins.
  - On a win, latch owner, op, addr and wr_line into registers, set `last_owner` to the winner, and go to BUSY.
- Op encoding: a requester with rd and wr both high is treated as a write.
- BUSY:
  - `mem_rd_req`/`mem_wr_req`/`mem_addr`/`mem_wr_line` are driven only from the latched registers; requester inputs are ignored.
  - On `mem_gnt`, go to IDLE.
  - If the op is a read, also capture `mem_rd_line` into the `m_rd_line` register.
- `mX_gnt = mem_gnt & (state==BUSY) & (owner==X)`. This is combinational with `mem_gnt`, so exactly one pulse goes to the owner.
- Requester contract:
  - A requester holds its request until its gnt.
  - It drops or changes the request at the edge ending the gnt cycle.
  - A request withdrawn before gnt is a protocol violation and is not checked.
- `m_rd_line` holds its value until the next read completes. Write completions never alter it.
- Reset values:
  - state = IDLE, `last_owner` = 1 (so requester 0 wins the first contention).
  - Outputs: `mem_rd_req`, `mem_wr_req`, `m0_gnt`, `m1_gnt` = 0; `mem_addr` = 0; `mem_wr_line` and `m_rd_line` = all zero.
- Reset mid-BUSY: the transaction is abandoned, and `mem_*_req` is low in the cycle after the reset edge. A `mem_gnt` arriving while in IDLE is ignored.

## Timing
- Arbitration: a request sampled at edge t drives `mem_*_req` high from cycle t+1.
- Completion: `mem_gnt` in cycle g gives `mX_gnt` in cycle g. `mem_*_req` is low in cycle g+1, and `m_rd_line` is valid from g+1.
- Idle gap: at least one IDLE cycle separates consecutive memory transactions, which lets `main_mem` observe its request falling.
- Back-to-back swap: when one cache does a dirty write-back then refill while the other cache is also waiting, the other cache's request is served between the two.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; requester 0 always wins when both are active. `last_owner` is still maintained but unused.
  - Undefined (default): round-robin as above.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic {IDLE, BUSY} arb_state_t`
  - `typedef enum logic {REQ_I = 0, REQ_D = 1} req_id_t`
  - `typedef enum logic {OP_RD, OP_WR} mem_op_t`
- `LINE_SIZE` stays a localparam derived from `LINE_ADDR_LEN`.
- Sub-module `arb_rr_pick` is a combinational 2-way picker:
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `valid`, `winner`.
  - Fixed-priority mode lives inside it.

## Test plan
Memory model latency is 20 cycles, gnt one cycle. Each scenario below is listed as stimulus → required response.

- **Single read:** only `m0_rd_req`, addr 0x05A → `mem_rd_req` high with addr 0x05A from t+1; `m0_gnt` once 20 cycles later; `m_rd_line` equals the model line from the next cycle; `m1_gnt` never pulses.
- **Simultaneous first contention:** m0 read 0x001 and m1 write 0x3FF in the same cycle after reset → m0 is served first. m1's write then goes out with its exact wr_line. `m_rd_line` is unchanged by the write.
- **Sustained contention:** both request continuously for 6 transactions → grants alternate 0,1,0,1,0,1. With `MEM_ARB_FIXED_PRIO_EN`, all 6 grants go to m0.
- **Write-back then refill on m1 while m0 waits:** m1 writes 0x010 and holds a pending read of 0x011 after gnt; m0 is waiting → order is m1 write, m0, m1 read; at least 1 idle cycle between each.
- **Reset mid-BUSY:** assert `rst` for 1 cycle 5 cycles into a read → `mem_rd_req` low the next cycle. A later stray `mem_gnt` produces no `mX_gnt`. The next request is arbitrated normally.
- **Rd and wr both high on m1:** m1 asserts both for addr 0x020 → `mem_wr_req`=1 and `mem_rd_req`=0 for the whole transaction.
